// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: start/busy/done handshake and operand/result bus of the shift sequencer.
interface shift_sequencer_if #(
    parameter int AMT_W = 4
);
    logic             start;
    logic [15:0]      in;
    logic [1:0]       op;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [15:0]      out;

    modport master (
        output start, in, op, amount,
        input  busy, done, out
    );

    modport slave (
        input  start, in, op, amount,
        output busy, done, out
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle N-bit shift built on one 16-bit single-step shifter.
// Defining SHIFT_SEQ_FAST4_EN adds a 4-bit step used while the remaining count is >= 4.
module shift_sequencer #(
    parameter int AMT_W = 4
) (
    input logic               clk,
    input logic               reset,
    shift_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [AMT_W-1:0] r_cnt;
    logic [AMT_W-1:0] w_cnt_nxt;
    logic [AMT_W-1:0] w_load_cnt;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nxt;
    logic [15:0]      r_out;
    logic [15:0]      w_out_nxt;

    // 00 pass, 01 LSL1, 10 LSR1, 11 ASR1
    function automatic logic [15:0] shift1(input logic [15:0] d, input logic [1:0] o);
        return (o == 2'b01) ? {d[14:0], 1'b0} :
               (o == 2'b10) ? {1'b0, d[15:1]} :
               (o == 2'b11) ? {d[15], d[15:1]} : d;
    endfunction

`ifdef SHIFT_SEQ_FAST4_EN
    logic w_fast;

    function automatic logic [15:0] shift4(input logic [15:0] d, input logic [1:0] o);
        return (o == 2'b01) ? {d[11:0], 4'b0000} :
               (o == 2'b10) ? {4'b0000, d[15:4]} :
               (o == 2'b11) ? {{4{d[15]}}, d[15:4]} : d;
    endfunction

    assign w_fast = r_cnt >= AMT_W'(4);
`endif

    // A pass op never needs shift cycles, so it goes straight to DONE.
    assign w_load_cnt = (bus.op == 2'b00) ? '0 : bus.amount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 2'b00;
            r_out   <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_out   <= w_out_nxt;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_op_nxt  = r_op;
        w_out_nxt = r_out;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_out_nxt = bus.in;
                    w_op_nxt  = bus.op;
                    w_cnt_nxt = w_load_cnt;
                    w_next    = (w_load_cnt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
`ifdef SHIFT_SEQ_FAST4_EN
                w_out_nxt = w_fast ? shift4(r_out, r_op) : shift1(r_out, r_op);
                w_cnt_nxt = r_cnt - (w_fast ? AMT_W'(4) : AMT_W'(1));
`else
                w_out_nxt = shift1(r_out, r_op);
                w_cnt_nxt = r_cnt - AMT_W'(1);
`endif
                w_next    = (w_cnt_nxt == '0) ? S_DONE : S_SHIFT;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.busy = r_state != S_IDLE;
    assign bus.done = r_state == S_DONE;
    assign bus.out  = r_out;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks of shift_sequencer against a shift-operator reference.
module tb_shift_sequencer;
    localparam int AMT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    shift_sequencer_if #(.AMT_W(AMT_W)) bus ();

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] o, input int a);
        int n = (o == 2'b00) ? 0 : a;
        case (o)
            2'b01:   return d << n;
            2'b10:   return d >> n;
            2'b11:   return 16'($signed(d) >>> n);
            default: return d;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input int a);
        int n = (o == 2'b00) ? 0 : a;
`ifdef SHIFT_SEQ_FAST4_EN
        return n / 4 + n % 4;
`else
        return n;
`endif
    endfunction

    // Issues one start, waits for done, and checks result, latency, busy and the single-cycle pulse.
    task automatic run_op(input logic [15:0] d, input logic [1:0] o, input int a, input string name);
        logic [15:0] exp_out = ref_shift(d, o, a);
        int          exp_lat = ref_lat(o, a);
        int          lat = 0;
        bus.start  = 1'b1;
        bus.in     = d;
        bus.op     = o;
        bus.amount = AMT_W'(a);
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.in     = 16'($urandom);
        bus.op     = 2'($urandom);
        bus.amount = AMT_W'($urandom);
        while (!bus.done && lat < 40) begin
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_during_shift: got %b want 1 at cycle %0d", name, bus.busy, lat);
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: done=%b after %0d cycles", name, bus.done, lat);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (bus.out !== exp_out) begin
            errors++;
            $display("FAIL %s out: got %h want %h (in=%h op=%b amt=%0d)", name, bus.out, exp_out, d, o, a);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b want 1", name, bus.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b want 0 0", name, bus.done, bus.busy);
        end
        checks++;
        if (bus.out !== exp_out) begin
            errors++;
            $display("FAIL %s out_hold: got %h want %h", name, bus.out, exp_out);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.in    = 16'hBEEF;
        bus.op    = 2'b01;
        bus.amount = AMT_W'(3);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b out=%h want 0 0 0000", bus.busy, bus.done, bus.out);
        end
        bus.start = 1'b0;
        reset     = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b out=%h want 0 0000", bus.busy, bus.out);
        end
    endtask

    task automatic test_directed();
        run_op(16'h0001, 2'b01, 3,  "lsl3");
        run_op(16'h8000, 2'b11, 15, "asr15");
        run_op(16'h8000, 2'b10, 15, "lsr15");
        run_op(16'hA5A5, 2'b00, 7,  "pass7");
        run_op(16'hA5A5, 2'b01, 0,  "lsl0");
        run_op(16'h7FFF, 2'b11, 4,  "asr4_pos");
        run_op(16'hF0F0, 2'b01, 8,  "lsl8");
    endtask

    task automatic test_ignore_start();
        int exp_lat = ref_lat(2'b01, 5);
        int done_cnt = 0;
        bus.start  = 1'b1;
        bus.in     = 16'h0003;
        bus.op     = 2'b01;
        bus.amount = AMT_W'(5);
        @(posedge clk); #1;
        for (int k = 1; k <= 12; k++) begin
            bus.start = (k == 1) || (k == exp_lat + 1);
            bus.in    = 16'hFFFF;
            @(posedge clk); #1;
            if (bus.done) begin
                done_cnt++;
                checks++;
                if (k !== exp_lat) begin
                    errors++;
                    $display("FAIL ignore_latency: done at %0d want %0d", k, exp_lat);
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d want 1", done_cnt);
        end
        checks++;
        if (bus.out !== 16'h0060) begin
            errors++;
            $display("FAIL ignore_out: got %h want 0060", bus.out);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        int done_cnt = 0;
        bus.start  = 1'b1;
        bus.in     = 16'($urandom);
        bus.op     = 2'b10;
        bus.amount = AMT_W'(10);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b out=%h want 0 0 0000", bus.busy, bus.done, bus.out);
        end
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt);
        end
        run_op(16'h1234, 2'b10, 10, "after_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_op(16'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, (1 << AMT_W) - 1)), "random");
    endtask

    task automatic test_back_to_back();
        run_op(16'h8001, 2'b11, 1,  "b2b_a");
        run_op(16'h8001, 2'b10, 1,  "b2b_b");
        run_op(16'hC3C3, 2'b00, 0,  "b2b_c");
        run_op(16'hC3C3, 2'b01, 15, "b2b_d");
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.in     = 16'h0000;
        bus.op     = 2'b00;
        bus.amount = '0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
